// File: rtl/alu_pkg.sv
// alu_pkg: opcode, FSM state and control-field definitions shared by alu_mc
package alu_pkg;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_SLL = 3'd4;
  localparam logic [2:0] OP_SRL = 3'd5;
  localparam logic [2:0] OP_SRA = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;
  localparam int SHIFT_SRC = 3;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/alu_mc_seq_multiplier.sv
// seq_multiplier: WIDTH-step shift-add unsigned multiplier
// Ports: clk, rst (sync, active-high); load captures a/b and clears the accumulator;
// step advances one bit; last flags the final step; product_next is the accumulator
// value that the current step will produce, so the caller can register it on that edge.
module seq_multiplier #(
  parameter int WIDTH = 32,
  localparam int CW = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] product_next
);
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;
  assign product_next = mplier[0] ? acc + mcand : acc;
  assign last = count == CW'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
      count  <= CW'(WIDTH);
    end else if (step && count != '0) begin
      acc    <= product_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CW'(1);
    end
  end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: handshaked ALU with registered result/flags and multi-cycle shift-add MUL
// Ports: clk, rst (sync, active-high); in_valid/in_ready accept inp1, inp2, shamt,
// ALUControl ([3] shift source, [2:0] op); out_valid/out_ready release out plus
// carry_out, isNeg, isZero, overflow.
module alu_mc import alu_pkg::*; #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  input  logic [SHW-1:0]   shamt,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             isNeg,
  output logic             isZero,
  output logic             overflow
);
  state_t             state;
  logic [2:0]         op;
  logic [SHW-1:0]     sh;
  logic               sub;
  logic               arith;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   res;
  logic               c;
  logic               ov;
  logic               mul_last;
  logic [2*WIDTH-1:0] prod;
  assign op    = ALUControl[2:0];
  assign sh    = ALUControl[SHIFT_SRC] ? shamt : inp2[SHW-1:0];
  assign sub   = op == OP_SUB;
  assign arith = op == OP_ADD || sub;
  // SUB is inp1 + ~inp2 + 1, so carry = no borrow and one adder serves both ops
  assign b_eff = sub ? ~inp2 : inp2;
  assign sum   = {1'b0, inp1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign c     = arith & sum[WIDTH];
  assign ov    = arith & (inp1[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != inp1[WIDTH-1]);
  always_comb begin
    res = sum[WIDTH-1:0];
    case (op)
      OP_AND:  res = inp1 & inp2;
      OP_XOR:  res = inp1 ^ inp2;
      OP_SLL:  res = inp1 << sh;
      OP_SRL:  res = inp1 >> sh;
      OP_SRA:  res = WIDTH'($signed(inp1) >>> sh);
      default: res = sum[WIDTH-1:0];
    endcase
  end
  assign in_ready = state == IDLE;
  assign isNeg    = out[WIDTH-1];
  assign isZero   = out == '0;
  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk          (clk),
    .rst          (rst),
    .load         (in_ready && in_valid && op == OP_MUL),
    .step         (state == BUSY),
    .a            (inp1),
    .b            (inp2),
    .last         (mul_last),
    .product_next (prod)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (op == OP_MUL) state <= BUSY;
          else begin
            state     <= DONE;
            out_valid <= 1'b1;
            out       <= res;
            carry_out <= c;
            overflow  <= ov;
          end
        end
        BUSY: if (mul_last) begin
          state     <= DONE;
          out_valid <= 1'b1;
          out       <= prod[WIDTH-1:0];
          carry_out <= 1'b0;
          overflow  <= |prod[2*WIDTH-1:WIDTH];
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc (WIDTH = 32)
module tb_alu_mc;
  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] inp1 = 0;
  logic [31:0] inp2 = 0;
  logic [4:0]  shamt = 0;
  logic [3:0]  ALUControl = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [31:0] out;
  logic        carry_out, isNeg, isZero, overflow;
  int checks = 0;
  int failures = 0;
  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inp1(inp1), .inp2(inp2), .shamt(shamt), .ALUControl(ALUControl),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .carry_out(carry_out), .isNeg(isNeg), .isZero(isZero), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b, input logic [4:0] s);
    ALUControl = ctrl;
    inp1 = a;
    inp2 = b;
    shamt = s;
    in_valid = 1;
    tick();
    in_valid = 0;
  endtask
  task automatic release_result(input string tag);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk({tag, "_rel_in_ready"}, in_ready, 1);
    chk({tag, "_rel_out_valid"}, out_valid, 0);
  endtask
  task automatic check_alu(input string tag, input logic [31:0] o, input logic cy, input logic ng, input logic zr, input logic vf);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out"}, out, o);
    chk({tag, "_carry"}, carry_out, cy);
    chk({tag, "_neg"}, isNeg, ng);
    chk({tag, "_zero"}, isZero, zr);
    chk({tag, "_ovf"}, overflow, vf);
  endtask
  initial begin
    int cyc;
    logic ready_seen;
    logic valid_seen;
    rst = 1;
    tick();
    tick();
    rst = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_zero", isZero, 1);
    chk("rst_carry", carry_out, 0);
    chk("rst_neg", isNeg, 0);
    chk("rst_ovf", overflow, 0);
    issue(4'b0000, 32'hFFFFFFFF, 32'h1, 0);
    check_alu("add_wrap", 32'h0, 1, 0, 1, 0);
    release_result("add_wrap");
    issue(4'b0001, 32'h80000000, 32'h1, 0);
    check_alu("sub_ovf", 32'h7FFFFFFF, 1, 0, 0, 1);
    release_result("sub_ovf");
    issue(4'b0001, 32'd3, 32'd5, 0);
    check_alu("sub_borrow", 32'hFFFFFFFE, 0, 1, 0, 0);
    release_result("sub_borrow");
    issue(4'b1110, 32'h80000000, 32'h0, 5'd4);
    check_alu("sra_shamt", 32'hF8000000, 0, 1, 0, 0);
    release_result("sra_shamt");
    issue(4'b0110, 32'h80000000, 32'h24, 5'd0);
    check_alu("sra_inp2", 32'hF8000000, 0, 1, 0, 0);
    release_result("sra_inp2");
    issue(4'b0010, 32'h0000F0F0, 32'h0000FF00, 0);
    check_alu("and", 32'h0000F000, 0, 0, 0, 0);
    release_result("and");
    issue(4'b0011, 32'h000000FF, 32'h0000000F, 0);
    check_alu("xor", 32'h000000F0, 0, 0, 0, 0);
    release_result("xor");
    issue(4'b1100, 32'h1, 32'h0, 5'd31);
    check_alu("sll", 32'h80000000, 0, 1, 0, 0);
    release_result("sll");
    issue(4'b0101, 32'h80000000, 32'd31, 5'd3);
    check_alu("srl", 32'h1, 0, 0, 0, 0);
    release_result("srl");
    issue(4'b1000, 32'd2, 32'd3, 5'd7);
    check_alu("add_ctl3", 32'd5, 0, 0, 0, 0);
    release_result("add_ctl3");
    issue(4'b0111, 32'h00010000, 32'h00010000, 0);
    cyc = 1;
    ready_seen = 0;
    while (!out_valid && cyc < 100) begin
      ready_seen |= in_ready;
      inp1 = $urandom;
      inp2 = $urandom;
      in_valid = 1;
      tick();
      cyc++;
    end
    in_valid = 0;
    chk("mul_latency", cyc, 33);
    chk("mul_busy_ready", ready_seen, 0);
    check_alu("mul_big", 32'h0, 0, 0, 1, 1);
    release_result("mul_big");
    issue(4'b0111, 32'd7, 32'd6, 0);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("mul7x6_latency", cyc, 33);
    for (int i = 0; i < 5; i++) begin
      check_alu("mul_hold", 32'h2A, 0, 0, 0, 0);
      tick();
    end
    check_alu("mul_hold_end", 32'h2A, 0, 0, 0, 0);
    release_result("mul_hold");
    issue(4'b0111, 32'd9, 32'd9, 0);
    for (int i = 0; i < 10; i++) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out", out, 0);
    valid_seen = 0;
    for (int i = 0; i < 40; i++) begin
      valid_seen |= out_valid;
      tick();
    end
    chk("abort_no_valid", valid_seen, 0);
    issue(4'b0000, 32'd2, 32'd2, 0);
    check_alu("add_after_abort", 32'd4, 0, 0, 0, 0);
    release_result("add_after_abort");
    rst = 1;
    issue(4'b0000, 32'd1, 32'd1, 0);
    rst = 0;
    chk("rst_accept_valid", out_valid, 0);
    chk("rst_accept_ready", in_ready, 1);
    chk("rst_accept_out", out, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised, handshaked successor to the single-cycle ALU in the csRISC datapath. It adds a valid/ready operand and result interface, registered outputs, and a corrected SUB. Flags are computed on the result, with signed overflow added. A multi-cycle shift-add MUL occupies the eighth opcode. The block sits between the register-read stage and writeback; the control unit stalls on `in_ready` / `out_valid`.

## Interface
- `WIDTH`, 32, datapath width; power of two, ≥ 8. Derived localparam `SHW = $clog2(WIDTH)`.
- `clk` in 1, sole clock, rising edge.
- `rst` in 1, reset: synchronous, active-high.
- `in_valid` in 1, operand transaction offered.
- `in_ready` out 1, block can accept; high only in IDLE.
- `inp1` in WIDTH, operand A.
- `inp2` in WIDTH, operand B.
- `shamt` in SHW, immediate shift amount.
- `ALUControl` in 4, encoding:
  - [3]: shift source, 1 = `shamt`, 0 = `inp2[SHW-1:0]`.
  - [2:0]: op.
- `out_valid` out 1, result held and valid.
- `out_ready` in 1, consumer takes result.
- `out` out WIDTH, registered result.
- `carry_out` out 1, registered carry.
- `isNeg` out 1, `out[WIDTH-1]`.
- `isZero` out 1, `out == 0`.
- `overflow` out 1, signed/product overflow.

## Operation
- Ops ([2:0]):
  - 000 ADD `inp1+inp2`.
  - 001 SUB `inp1-inp2`, computed as `inp1 + ~inp2 + 1`.
  - 010 AND.
  - 011 XOR.
  - 100 SLL.
  - 101 SRL.
  - 110 SRA, arithmetic: fills with `inp1` MSB.
  - 111 MUL, low WIDTH bits of the unsigned product.
- Carry:
  - ADD: carry out of the MSB.
  - SUB: carry out of `inp1 + ~inp2 + 1`, i.e. 1 = no borrow (`inp1 ≥ inp2` unsigned).
  - All other ops: 0.
- Overflow:
  - ADD/SUB: signed overflow.
  - MUL: 1 iff the upper WIDTH bits of the 2·WIDTH product are nonzero.
  - Others: 0.
- `isNeg` and `isZero` are derived from the registered result `out`, never from operands.
- `ALUControl[3]` affects shifts only; it is ignored for other ops.
- Operands and ALUControl are captured at acceptance (`in_valid && in_ready`). Input changes afterwards have no effect.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, accept, op ≠ MUL → DONE; result and flags registered on the same edge.
  - IDLE, accept, op = MUL → BUSY; load multiplicand, multiplier, zeroed 2·WIDTH accumulator, count = WIDTH.
  - BUSY: each cycle, add the shifted multiplicand if multiplier LSB = 1; shift; decrement count. Count reaches 0 → DONE with result and flags registered.
  - DONE: hold all outputs stable while `out_ready` = 0. When `out_ready` = 1 → IDLE.
  - No early termination; MUL duration is fixed.
- `in_ready` = (state == IDLE). No accept in BUSY or DONE.

## Timing
- Reset (any state, including mid-MUL), on the next edge:
  - state = IDLE, `in_ready` = 1, `out_valid` = 0.
  - `out`, `carry_out`, `overflow`, `isNeg` = 0; `isZero` = 1 (tracks `out`).
  - MUL accumulator and count cleared.
- Single-cycle ops: accept at edge N → `out_valid` high after edge N, i.e. visible in cycle N+1. Latency 1.
- MUL: accept at edge N → `out_valid` high after edge N+WIDTH. Latency WIDTH+1 cycles.
- Result is released at the edge where `out_valid && out_ready`. `in_ready` rises in the following cycle. Peak throughput: one op per 2 cycles.
- Simultaneous `rst` and accept: reset wins; the transaction is dropped.
- `out_ready` outside DONE is ignored.

## Structure
- Package `alu_pkg`:
  - Op localparams: `OP_ADD` … `OP_MUL`.
  - FSM state encoding: IDLE / BUSY / DONE.
  - Shift-source bit index.
- Sub-module `seq_multiplier`: WIDTH-parametrised shift-add datapath with a load/step/done interface, driven by the `alu_mc` FSM.
- Adder, shifter and logic ops are implemented inline in combinational logic feeding the result register.

## Test plan
All scenarios use WIDTH = 32.
- Reset: `rst` high for 2 cycles → `in_ready` = 1, `out_valid` = 0, `out` = 0, `isZero` = 1, all other flags 0.
- ADD: 0xFFFFFFFF + 0x00000001 → `out` = 0, `carry_out` = 1, `isZero` = 1, `overflow` = 0; `out_valid` in the cycle after acceptance.
- SUB: 0x80000000 − 0x00000001 → `out` = 0x7FFFFFFF, `overflow` = 1, `carry_out` = 1, `isNeg` = 0. SUB 3 − 5 → `out` = 0xFFFFFFFE, `carry_out` = 0, `isNeg` = 1.
- SRA:
  - 0x80000000, `ALUControl` = 4'b1110, `shamt` = 4 → 0xF8000000, `isNeg` = 1.
  - Same with `ALUControl` = 4'b0110, `inp2` = 0x24, `shamt` = 0 → 0xF8000000.
- MUL:
  - 0x00010000 × 0x00010000 → `out` = 0, `overflow` = 1, `isZero` = 1, `out_valid` exactly 33 cycles after acceptance.
  - 7 × 6 → 0x2A, `overflow` = 0.
  - `in_ready` stays 0 throughout; toggling `inp1`/`inp2` during BUSY does not change the result.
- Backpressure and abort:
  - `out_ready` held 0 for 5 cycles in DONE → `out` and flags stable, `in_ready` = 0.
  - `rst` asserted 10 cycles into a MUL → IDLE next cycle, `out_valid` never asserted; a following ADD 2 + 2 returns 4.
